// File: rtl/redirect_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage redirect pipeline.
// Tracks EX/MEM/WB destinations, selects operand sources, raises load-use stalls.
module redirect_hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_we,
    input  logic [REG_AW-1:0] id_rw,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              stat_clr,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rw,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              v;
        logic              we;
        logic [REG_AW-1:0] rw;
        logic              ld;
    } stage_t;

    stage_t ex_q, mem_q, wb_q;

    logic ex_prod, mem_prod, wb_prod;
    logic a_ok, b_ok;
    logic a_ex, a_mem, a_wb;
    logic b_ex, b_mem, b_wb;

    assign ex_prod  = ex_q.v  & ex_q.we  & (ex_q.rw  != '0);
    assign mem_prod = mem_q.v & mem_q.we & (mem_q.rw != '0);
    assign wb_prod  = wb_q.v  & wb_q.we  & (wb_q.rw  != '0);

    assign a_ok  = id_rs_used & (id_rs != '0);
    assign b_ok  = id_rt_used & (id_rt != '0);

    assign a_ex  = a_ok & ex_prod  & (ex_q.rw  == id_rs);
    assign a_mem = a_ok & mem_prod & (mem_q.rw == id_rs);
    assign a_wb  = a_ok & wb_prod  & (wb_q.rw  == id_rs);
    assign b_ex  = b_ok & ex_prod  & (ex_q.rw  == id_rt);
    assign b_mem = b_ok & mem_prod & (mem_q.rw == id_rt);
    assign b_wb  = b_ok & wb_prod  & (wb_q.rw  == id_rt);

    // An EX load match shadows older producers; the value is not ready, so the
    // select is 0 and the stall covers the cycle.
    always_comb begin
        fwd_a = 2'd0;
        if (a_ex)       fwd_a = ex_q.ld ? 2'd0 : 2'd1;
        else if (a_mem) fwd_a = 2'd2;
        else if (a_wb)  fwd_a = 2'd3;
    end

    always_comb begin
        fwd_b = 2'd0;
        if (b_ex)       fwd_b = ex_q.ld ? 2'd0 : 2'd1;
        else if (b_mem) fwd_b = 2'd2;
        else if (b_wb)  fwd_b = 2'd3;
    end

    assign stall = id_valid & ~flush & ex_q.ld & (a_ex | b_ex);
    assign rf_we = wb_prod;
    assign rf_rw = wb_q.rw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (flush || stall) begin
                ex_q <= '0;
            end else begin
                ex_q.v  <= id_valid;
                ex_q.we <= id_we;
                ex_q.rw <= id_rw;
                ex_q.ld <= id_is_load;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stat_clr) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_redirect_hazard_ctrl.sv
// Bench for redirect_hazard_ctrl: directed vector table, corner sequences,
// and random traffic against a stage-list reference model.
module tb_redirect_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs_used, id_rt_used, id_we, id_is_load, flush, stat_clr;
    logic [4:0] id_rs, id_rt, id_rw;
    logic       stall, rf_we;
    logic [1:0] fwd_a, fwd_b;
    logic [4:0] rf_rw;
    logic [15:0] stall_cnt;
    logic       stall4, rf_we4;
    logic [1:0] fwd_a4, fwd_b4;
    logic [4:0] rf_rw4;
    logic [3:0] stall_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    redirect_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_we(id_we), .id_rw(id_rw),
        .id_is_load(id_is_load), .flush(flush), .stat_clr(stat_clr), .stall(stall),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .rf_we(rf_we), .rf_rw(rf_rw), .stall_cnt(stall_cnt)
    );

    redirect_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_we(id_we), .id_rw(id_rw),
        .id_is_load(id_is_load), .flush(flush), .stat_clr(stat_clr), .stall(stall4),
        .fwd_a(fwd_a4), .fwd_b(fwd_b4), .rf_we(rf_we4), .rf_rw(rf_rw4), .stall_cnt(stall_cnt4)
    );

    typedef struct {
        logic v; logic [4:0] rs; logic [4:0] rt; logic rsu; logic rtu;
        logic we; logic [4:0] rw; logic ld; logic fl; logic clr;
    } in_t;

    typedef struct {
        logic st; logic [1:0] fa; logic [1:0] fb; logic ca; logic cb;
        logic rfwe; logic [4:0] rfrw; int c16; int c4;
    } exp_t;

    typedef struct { in_t i; exp_t e; } vec_t;

    // Reference: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct { bit v; bit we; bit ld; int rw; } ent_t;
    ent_t pipe[3];
    int m16, m4;

    function automatic in_t mk_in(logic v, int rs, int rt, logic rsu, logic rtu,
                                  logic we, int rw, logic ld, logic fl, logic clr);
        in_t r;
        r.v = v; r.rs = 5'(rs); r.rt = 5'(rt); r.rsu = rsu; r.rtu = rtu;
        r.we = we; r.rw = 5'(rw); r.ld = ld; r.fl = fl; r.clr = clr;
        return r;
    endfunction

    function automatic exp_t mk_exp(logic st, int fa, int fb, logic ca, logic cb,
                                    logic rfwe, int rfrw, int cnt);
        exp_t r;
        r.st = st; r.fa = 2'(fa); r.fb = 2'(fb); r.ca = ca; r.cb = cb;
        r.rfwe = rfwe; r.rfrw = 5'(rfrw); r.c16 = cnt; r.c4 = cnt;
        return r;
    endfunction

    function automatic void port_sel(input logic used, input int a, output logic [1:0] s,
                                     output logic care, output bit lu);
        s = 2'd0; care = 1'b1; lu = 1'b0;
        if (used && a != 0) begin
            for (int k = 0; k < 3; k++) begin
                if (pipe[k].v && pipe[k].we && pipe[k].rw == a) begin
                    if (k == 0 && pipe[0].ld) begin
                        care = 1'b0; lu = 1'b1;
                    end else begin
                        s = 2'(k + 1);
                    end
                    break;
                end
            end
        end
    endfunction

    function automatic exp_t model_exp(in_t i);
        exp_t e; bit lua, lub;
        port_sel(i.rsu, int'(i.rs), e.fa, e.ca, lua);
        port_sel(i.rtu, int'(i.rt), e.fb, e.cb, lub);
        e.st   = i.v && !i.fl && (lua || lub);
        e.rfwe = pipe[2].v && pipe[2].we && pipe[2].rw != 0;
        e.rfrw = 5'(pipe[2].rw);
        e.c16  = m16;
        e.c4   = m4;
        return e;
    endfunction

    function automatic void model_step(in_t i, logic st);
        if (i.clr) begin
            m16 = 0; m4 = 0;
        end else if (st) begin
            if (m16 < 65535) m16++;
            if (m4 < 15) m4++;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (i.fl || st) pipe[0] = '{v: 1'b0, we: 1'b0, ld: 1'b0, rw: 0};
        else            pipe[0] = '{v: i.v, we: i.we, ld: i.ld, rw: int'(i.rw)};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{v: 1'b0, we: 1'b0, ld: 1'b0, rw: 0};
        m16 = 0; m4 = 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input in_t i);
        id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_rs_used = i.rsu; id_rt_used = i.rtu;
        id_we = i.we; id_rw = i.rw; id_is_load = i.ld; flush = i.fl; stat_clr = i.clr;
    endtask

    // Called just after a rising edge; checks mid-cycle, then steps across the next edge.
    task automatic cycle(input in_t i, input exp_t te, input bit use_tbl, input string tag);
        exp_t e, m;
        drive(i);
        @(negedge clk);
        m = model_exp(i);
        e = use_tbl ? te : m;
        chk({tag, ".stall"}, 32'(stall), 32'(e.st));
        if (e.ca) chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(e.fa));
        if (e.cb) chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(e.fb));
        chk({tag, ".rf_we"}, 32'(rf_we), 32'(e.rfwe));
        if (e.rfwe) chk({tag, ".rf_rw"}, 32'(rf_rw), 32'(e.rfrw));
        chk({tag, ".cnt16"}, 32'(stall_cnt), 32'(e.c16));
        chk({tag, ".cnt4"}, 32'(stall_cnt4), 32'(e.c4));
        @(posedge clk);
        model_step(i, m.st);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".stall"}, 32'(stall), 0);
        chk({tag, ".fwd_a"}, 32'(fwd_a), 0);
        chk({tag, ".fwd_b"}, 32'(fwd_b), 0);
        chk({tag, ".rf_we"}, 32'(rf_we), 0);
        chk({tag, ".rf_rw"}, 32'(rf_rw), 0);
        chk({tag, ".cnt16"}, 32'(stall_cnt), 0);
        chk({tag, ".cnt4"}, 32'(stall_cnt4), 0);
    endtask

    vec_t tbl[$];
    in_t  nop, lw12, rd;
    exp_t dc;

    initial begin
        nop = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dc  = mk_exp(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        rst = 1'b1;
        drive(mk_in(1, 3, 3, 1, 1, 1, 3, 1, 0, 0));
        #1;
        check_all_zero("reset");
        drive(nop);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //                   v  rs rt rsu rtu we rw ld fl clr      st fa fb ca cb rfwe rfrw cnt
        tbl.push_back('{mk_in(1, 1, 2, 1, 1, 1, 3, 0, 0, 0), mk_exp(0, 0, 0, 1, 1, 0, 0, 0)});
        tbl.push_back('{mk_in(1, 3, 3, 1, 1, 1, 4, 0, 0, 0), mk_exp(0, 1, 1, 1, 1, 0, 0, 0)});
        tbl.push_back('{mk_in(1, 3, 0, 1, 1, 1, 8, 0, 0, 0), mk_exp(0, 2, 0, 1, 1, 0, 0, 0)});
        tbl.push_back('{mk_in(1, 3, 3, 1, 1, 0, 0, 0, 0, 0), mk_exp(0, 3, 3, 1, 1, 1, 3, 0)});
        tbl.push_back('{mk_in(1, 1, 0, 1, 0, 1, 5, 1, 0, 0), mk_exp(0, 0, 0, 1, 1, 1, 4, 0)});
        tbl.push_back('{mk_in(1, 5, 1, 1, 1, 1, 6, 0, 0, 0), mk_exp(1, 0, 0, 0, 1, 1, 8, 0)});
        tbl.push_back('{mk_in(1, 5, 1, 1, 1, 1, 6, 0, 0, 0), mk_exp(0, 2, 0, 1, 1, 0, 0, 1)});
        tbl.push_back('{nop,                                 mk_exp(0, 0, 0, 1, 1, 1, 5, 1)});
        tbl.push_back('{nop,                                 mk_exp(0, 0, 0, 1, 1, 0, 0, 1)});
        tbl.push_back('{nop,                                 mk_exp(0, 0, 0, 1, 1, 1, 6, 1)});
        tbl.push_back('{mk_in(1, 0, 0, 0, 0, 1, 7, 1, 0, 0), mk_exp(0, 0, 0, 1, 1, 0, 0, 1)});
        tbl.push_back('{mk_in(1, 0, 0, 0, 0, 1, 7, 0, 0, 0), mk_exp(0, 0, 0, 1, 1, 0, 0, 1)});
        tbl.push_back('{mk_in(1, 7, 7, 1, 0, 1, 0, 0, 0, 0), mk_exp(0, 1, 0, 1, 1, 0, 0, 1)});
        tbl.push_back('{mk_in(1, 0, 0, 1, 1, 0, 0, 0, 0, 0), mk_exp(0, 0, 0, 1, 1, 1, 7, 1)});
        tbl.push_back('{nop,                                 mk_exp(0, 0, 0, 1, 1, 1, 7, 1)});
        tbl.push_back('{nop,                                 mk_exp(0, 0, 0, 1, 1, 0, 0, 1)});
        tbl.push_back('{mk_in(1, 0, 0, 0, 0, 1, 9, 1, 0, 0), mk_exp(0, 0, 0, 1, 1, 0, 0, 1)});
        tbl.push_back('{mk_in(1, 9, 2, 1, 1, 1, 10, 0, 1, 0), mk_exp(0, 0, 0, 0, 1, 0, 0, 1)});
        tbl.push_back('{mk_in(1, 9, 0, 1, 0, 0, 0, 0, 0, 0), mk_exp(0, 2, 0, 1, 1, 0, 0, 1)});
        tbl.push_back('{mk_in(1, 0, 0, 0, 0, 1, 11, 1, 0, 0), mk_exp(0, 0, 0, 1, 1, 1, 9, 1)});
        tbl.push_back('{mk_in(1, 1, 11, 1, 0, 0, 0, 0, 0, 0), mk_exp(0, 0, 0, 1, 1, 0, 0, 1)});
        tbl.push_back('{nop,                                 mk_exp(0, 0, 0, 1, 1, 0, 0, 1)});
        foreach (tbl[n]) cycle(tbl[n].i, tbl[n].e, 1'b1, $sformatf("vec%0d", n));

        // Reset in the middle of a load-use with valid entries in every stage.
        cycle(mk_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0), dc, 1'b0, "pre_r1");
        cycle(mk_in(1, 0, 0, 0, 0, 1, 2, 0, 0, 0), dc, 1'b0, "pre_r2");
        cycle(mk_in(1, 0, 0, 0, 0, 1, 5, 1, 0, 0), dc, 1'b0, "pre_lw5");
        rd = mk_in(1, 5, 1, 1, 1, 1, 6, 0, 0, 0);
        drive(rd);
        #2;
        chk("midrst.pre_stall", 32'(stall), 1);
        chk("midrst.pre_rf_we", 32'(rf_we), 1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        model_reset();
        drive(nop);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(rd, dc, 1'b0, "post_rst");

        // Saturation: lw r12 reading r12 stalls every other cycle.
        cycle(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), dc, 1'b0, "sat_clr");
        cycle(nop, dc, 1'b0, "sat_nop1");
        cycle(nop, dc, 1'b0, "sat_nop2");
        cycle(nop, dc, 1'b0, "sat_nop3");
        lw12 = mk_in(1, 12, 0, 1, 0, 1, 12, 1, 0, 0);
        for (int n = 0; n < 34; n++) cycle(lw12, dc, 1'b0, $sformatf("sat%0d", n));
        chk("sat.cnt4", 32'(stall_cnt4), 15);
        chk("sat.cnt16", 32'(stall_cnt), 17);
        cycle(lw12, dc, 1'b0, "sat_odd");
        lw12.clr = 1'b1;
        drive(lw12);
        @(negedge clk);
        chk("clr.stall", 32'(stall), 1);
        @(posedge clk);
        model_step(lw12, 1'b1);
        #1;
        chk("clr.cnt16", 32'(stall_cnt), 0);
        chk("clr.cnt4", 32'(stall_cnt4), 0);

        for (int n = 0; n < 3000; n++) begin
            in_t r;
            r.v   = ($urandom_range(0, 7) != 0);
            r.rs  = 5'($urandom_range(0, 7));
            r.rt  = 5'($urandom_range(0, 7));
            r.rsu = 1'($urandom);
            r.rtu = 1'($urandom);
            r.we  = ($urandom_range(0, 3) != 0);
            r.rw  = 5'($urandom_range(0, 7));
            r.ld  = r.we & ($urandom_range(0, 2) == 0);
            r.fl  = ($urandom_range(0, 7) == 0);
            r.clr = ($urandom_range(0, 63) == 0);
            cycle(r, dc, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
